// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst slave backed by a 64-bit word array.
// Independent read and write FSMs; INCR and FIXED bursts.
module axi_burst_mem_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    input  logic [1:0]        arburst,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    output logic              arready,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    output logic              rlast,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    input  logic [1:0]        awburst,
    input  logic [7:0]        awlen,
    output logic              awready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = ADDR_W + 1;

    typedef enum logic {R_IDLE, R_BEAT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [63:0] mem [DEPTH];

    // Addresses below the base map to a sentinel that never increments back into range.
    function automatic logic [IW-1:0] to_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        if (a < BASE_ADDR)
            return {1'b1, {ADDR_W{1'b0}}};
        return {1'b0, off} >> 3;
    endfunction

    r_state_t        r_state;
    logic [IW-1:0]   r_idx;
    logic [7:0]      r_len;
    logic [7:0]      r_cnt;
    logic            r_fixed;
    logic            r_err;
    logic            r_inr;

    assign r_inr = r_idx < IW'(DEPTH);
    assign rdata = (rvalid && r_inr) ? mem[r_idx[AW-1:0]] : '0;
    assign rresp = !rvalid ? 2'b00 :
                   !r_inr  ? 2'b11 :
                   r_err   ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: if (arvalid) begin
                    r_idx   <= to_idx(araddr);
                    r_len   <= arlen;
                    r_cnt   <= '0;
                    r_err   <= (arsize != 3'd3) || arburst[1];
                    r_fixed <= (arburst == 2'b00) && (arsize == 3'd3);
                    rvalid  <= 1'b1;
                    rlast   <= (arlen == 8'd0);
                    arready <= 1'b0;
                    r_state <= R_BEAT;
                end
                R_BEAT: if (rready) begin
                    if (rlast) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        rlast <= (r_cnt + 8'd1 == r_len);
                        if (!r_fixed)
                            r_idx <= r_idx + IW'(1);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    w_state_t        w_state;
    logic [IW-1:0]   w_idx;
    logic [7:0]      w_len;
    logic [7:0]      w_cnt;
    logic            w_fixed;
    logic            w_dec;
    logic            w_slv;
    logic            w_inr;
    logic            w_fire;
    logic            w_at_len;
    logic            w_end;

    assign w_inr    = w_idx < IW'(DEPTH);
    assign w_fire   = wvalid && wready;
    assign w_at_len = (w_cnt == w_len);
    assign w_end    = w_at_len || wlast;

    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_inr) begin
            for (int b = 0; b < 8; b++)
                if (wstrb[b])
                    mem[w_idx[AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: if (awvalid) begin
                    w_idx   <= to_idx(awaddr);
                    w_len   <= awlen;
                    w_cnt   <= '0;
                    w_fixed <= (awburst == 2'b00);
                    w_dec   <= 1'b0;
                    w_slv   <= awburst[1];
                    awready <= 1'b0;
                    wready  <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    if (w_end) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                        bresp   <= (w_dec || !w_inr)            ? 2'b11 :
                                   (w_slv || (w_at_len != wlast)) ? 2'b10 : 2'b00;
                    end else begin
                        w_cnt <= w_cnt + 8'd1;
                        w_dec <= w_dec || !w_inr;
                        if (!w_fixed)
                            w_idx <= w_idx + IW'(1);
                    end
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    bresp   <= 2'b00;
                    awready <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomized bench for axi_burst_mem_slave against a
// byte-address reference model of the word array.
module tb_axi_burst_mem_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mm [DEPTH];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    axi_burst_mem_slave #(
        .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arburst(arburst),
        .arlen(arlen), .arsize(arsize), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst),
        .awlen(awlen), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word index of a beat from byte-address arithmetic; -1 when out of range.
    function automatic longint m_idx(input logic [31:0] a, input int beat,
                                     input bit fixed);
        logic [31:0] off;
        longint      i;
        if (a < BASE)
            return -1;
        off = (a - BASE) >> 3;
        i = longint'({32'd0, off}) + (fixed ? 0 : beat);
        return (i >= DEPTH) ? -1 : i;
    endfunction

    task automatic do_read(input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input int stall0, input int stall_max);
        bit          err, fixed;
        longint      ix;
        logic [63:0] ed;
        logic [1:0]  er;
        int          n;
        err   = (size != 3'd3) || (burst > 2'b01);
        fixed = (burst == 2'b00) && !err;
        @(posedge clk); #1;
        araddr = a; arlen = len; arburst = burst; arsize = size;
        arvalid = 1'b1;
        @(negedge clk);
        chk("arready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            ix = m_idx(a, i, fixed);
            ed = (ix < 0) ? 64'd0 : mm[ix];
            er = (ix < 0) ? 2'b11 : (err ? 2'b10 : 2'b00);
            n  = (i == 0) ? stall0 : int'($urandom_range(0, stall_max));
            rready = 1'b0;
            for (int s = 0; s < n; s++) begin
                @(negedge clk);
                chk("r_hold_data", rdata, ed);
                chk("r_hold_ctl", 64'({rvalid, rlast, rresp}),
                    64'({1'b1, i == int'(len), er}));
                @(posedge clk); #1;
            end
            rready = 1'b1;
            @(negedge clk);
            chk("rdata", rdata, ed);
            chk("r_ctl", 64'({rvalid, rlast, rresp}),
                64'({1'b1, i == int'(len), er}));
            @(posedge clk); #1;
        end
        rready = 1'b0;
        @(negedge clk);
        chk("r_done", 64'({rvalid, arready}), 64'b01);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input int wl_at,
                            input int gap_max, input int bdly);
        bit         fixed, dec, slv, done, end_now;
        longint     ix;
        int         i, n;
        logic [1:0] exp;
        fixed = (burst == 2'b00);
        dec   = 1'b0;
        slv   = burst[1];
        @(posedge clk); #1;
        awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
        @(negedge clk);
        chk("awready", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        done = 1'b0;
        i = 0;
        while (!done) begin
            n = int'($urandom_range(0, gap_max));
            for (int g = 0; g < n; g++) begin
                @(posedge clk); #1;
            end
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (wl_at < 0) ? (i == int'(len)) : (i == wl_at);
            @(negedge clk);
            chk("wready", 64'(wready), 64'd1);
            ix = m_idx(a, i, fixed);
            if (ix < 0)
                dec = 1'b1;
            else
                for (int b = 0; b < 8; b++)
                    if (ws[i][b])
                        mm[ix][8*b +: 8] = wd[i][8*b +: 8];
            end_now = (i == int'(len)) || wlast;
            if (end_now && ((i == int'(len)) != wlast))
                slv = 1'b1;
            @(posedge clk); #1;
            wvalid = 1'b0;
            wlast  = 1'b0;
            done = end_now;
            i++;
        end
        exp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        n = int'($urandom_range(0, bdly));
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            chk("b_hold", 64'({bvalid, bresp}), 64'({1'b1, exp}));
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(negedge clk);
        chk("bresp", 64'({bvalid, bresp}), 64'({1'b1, exp}));
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("b_done", 64'({bvalid, awready, wready}), 64'b010);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"},
            64'({arready, awready, rvalid, rlast, rresp,
                 wready, bvalid, bresp}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00}));
        chk({tag, "_rdata"}, rdata, 64'd0);
    endtask

    initial begin
        logic [63:0] old;
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  bu;
        logic [2:0]  sz;
        int          wl;

        rst = 1'b1;
        araddr = '0; arvalid = 0; arburst = 0; arlen = 0; arsize = 3'd3;
        rready = 0;
        awaddr = '0; awvalid = 0; awburst = 0; awlen = 0;
        wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        for (int k = 0; k < DEPTH; k++) begin
            wd[k] = {$urandom, $urandom};
            ws[k] = 8'hFF;
        end
        do_write(BASE, 8'(DEPTH - 1), 2'b01, -1, 0, 0);

        wd[0] = 64'h1111_2222_3333_4444; ws[0] = 8'hFF;
        do_write(BASE, 8'd0, 2'b01, -1, 0, 0);
        do_read(BASE, 8'd0, 2'b01, 3'd3, 0, 0);

        do_read(BASE + 32'd8, 8'd1, 2'b01, 3'd3, 3, 0);

        wd[0] = 64'd0; ws[0] = 8'hFF;
        do_write(BASE + 32'h18, 8'd0, 2'b01, -1, 0, 0);
        wd[0] = 64'hAAAA_BBBB_CCCC_DDDD; ws[0] = 8'h0F;
        wd[1] = '1;                      ws[1] = 8'hFF;
        do_write(BASE + 32'h18, 8'd1, 2'b01, -1, 0, 0);
        do_read(BASE + 32'h18, 8'd1, 2'b01, 3'd3, 0, 0);

        do_read(32'h7FFF_FFF8, 8'd0, 2'b01, 3'd3, 0, 0);
        wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hFF;
        do_write(BASE + 32'h50, 8'd1, 2'b01, 0, 0, 0);

        do_read(BASE + 32'h8, 8'd3, 2'b00, 3'd3, 0, 1);
        do_read(BASE + 32'h10, 8'd1, 2'b01, 3'd2, 0, 0);
        do_read(BASE, 8'd255, 2'b01, 3'd3, 0, 0);

        // Reset during beat 1 of a four-beat read.
        @(posedge clk); #1;
        araddr = BASE + 32'h20; arlen = 8'd3; arburst = 2'b01;
        arsize = 3'd3; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_beat1", rdata, mm[5]);
        rready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("mid_reset");
        do_read(BASE + 32'h30, 8'd0, 2'b01, 3'd3, 0, 0);

        // Read and write beats to word 5 in the same cycle.
        @(posedge clk); #1;
        araddr = BASE + 32'h28; arlen = 0; arburst = 2'b01; arsize = 3'd3;
        awaddr = BASE + 32'h28; awlen = 0; awburst = 2'b01;
        arvalid = 1'b1; awvalid = 1'b1;
        @(negedge clk);
        chk("rw_ready", 64'({arready, awready}), 64'b11);
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0;
        old = mm[5];
        wvalid = 1'b1; wdata = 64'h5555_5555_5555_5555; wstrb = 8'hFF;
        wlast = 1'b1; rready = 1'b1;
        @(negedge clk);
        chk("rw_old", rdata, old);
        chk("rw_wready", 64'(wready), 64'd1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        mm[5] = 64'h5555_5555_5555_5555;
        @(negedge clk);
        chk("rw_b", 64'({bvalid, bresp, rvalid}), 64'b1000);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        do_read(BASE + 32'h28, 8'd0, 2'b01, 3'd3, 0, 0);

        for (int t = 0; t < 60; t++) begin
            a   = BASE - 32'd32 + 32'($urandom_range(0, 8 * DEPTH + 64));
            len = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                bu = 2'($urandom_range(0, 3));
                sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                 : 3'd3;
                do_read(a, len, bu, sz, int'($urandom_range(0, 2)), 2);
            end else begin
                bu = 2'($urandom_range(0, 1));
                wl = ($urandom_range(0, 5) == 0)
                     ? int'($urandom_range(0, int'(len) + 1)) : -1;
                for (int k = 0; k < 17; k++) begin
                    wd[k] = {$urandom, $urandom};
                    ws[k] = 8'($urandom);
                end
                do_write(a, len, bu, wl, 1, 2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
